// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: FSM state encodings and default port widths for the data-memory arbiter.
package mem_port_arbiter_pkg;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_RD} state_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: core-side request/response bundle; master = cores, slave = arbiter.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_CORES = 3,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
);
  logic [NUM_CORES-1:0]        req;
  logic [NUM_CORES-1:0]        we;
  logic [NUM_CORES*ADDR_W-1:0] addr;
  logic [NUM_CORES*DATA_W-1:0] wdata;
  logic [NUM_CORES-1:0]        grant;
  logic [NUM_CORES-1:0]        rvalid;
  logic [DATA_W-1:0]           rdata;
  modport master (output req, we, addr, wdata, input grant, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output grant, rvalid, rdata);
endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; winner is the first requester after ptr, modulo N.
module rr_pick #(
  parameter int N = 3,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] win,
  output logic         vld
);
  always_comb begin
    win = '0;
    vld = |req;
    // scan farthest-first so the closest requester after ptr is assigned last
    for (int k = N; k >= 1; k--)
      if (req[W'((int'(ptr) + k) % N)]) win = W'((int'(ptr) + k) % N);
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one RAM port between cores, one access in flight.
// Define ARB_STATS_EN to add saturating conflict_cnt/access_cnt outputs.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_CORES = 3,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MEM_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave cif,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
`ifdef ARB_STATS_EN
  output logic [15:0]       conflict_cnt,
  output logic [15:0]       access_cnt,
`endif
  output logic              busy
);
  localparam int W = $clog2(NUM_CORES);
  state_t                 state_q, state_d;
  logic [W-1:0]           win_q, win_d, ptr_q, ptr_d, pick;
  logic                   pick_vld, we_q, we_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]             lat_q, lat_d;
  logic [NUM_CORES-1:0]   rvalid_q, rvalid_d;
  rr_pick #(.N(NUM_CORES), .W(W)) u_pick (.req(cif.req), .ptr(ptr_q), .win(pick), .vld(pick_vld));
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ptr_d    = ptr_q;
    lat_d    = lat_q;
    rdata_d  = rdata_q;
    rvalid_d = '0;
    case (state_q)
      ST_IDLE: if (pick_vld) begin
        state_d = ST_ISSUE;
        win_d   = pick;
        we_d    = cif.we[pick];
        addr_d  = cif.addr[int'(pick)*ADDR_W +: ADDR_W];
        wdata_d = cif.wdata[int'(pick)*DATA_W +: DATA_W];
      end
      ST_ISSUE: begin
        ptr_d   = win_q;
        lat_d   = 2'(MEM_LAT - 1);
        state_d = we_q ? ST_IDLE : ST_WAIT_RD;
      end
      ST_WAIT_RD: if (lat_q != '0) lat_d = lat_q - 2'd1;
      else begin
        rdata_d         = mem_rdata;
        rvalid_d[win_q] = 1'b1;
        state_d         = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q  <= ST_IDLE;
      win_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ptr_q    <= W'(NUM_CORES - 1);
      lat_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ptr_q    <= ptr_d;
      lat_q    <= lat_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  // the latched request holds the RAM address/data stable through WAIT_RD
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_we     = (state_q == ST_ISSUE) && we_q;
  assign busy       = state_q != ST_IDLE;
  assign cif.grant  = (state_q == ST_ISSUE) ? NUM_CORES'(1) << win_q : '0;
  assign cif.rvalid = rvalid_q;
  assign cif.rdata  = rdata_q;
`ifdef ARB_STATS_EN
  logic [15:0] conflict_q, conflict_d, access_q, access_d;
  always_comb begin
    conflict_d = (state_q == ST_IDLE && (cif.req & (cif.req - 1'b1)) != '0 && conflict_q != '1) ? conflict_q + 16'd1 : conflict_q;
    access_d   = (state_q == ST_ISSUE && access_q != '1) ? access_q + 16'd1 : access_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      conflict_q <= '0;
      access_q   <= '0;
    end else begin
      conflict_q <= conflict_d;
      access_q   <= access_d;
    end
  assign conflict_cnt = conflict_q;
  assign access_cnt   = access_q;
`endif
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter that shares the single data-memory port of the matrix-multiplication processor between NUM_CORES processing cores.
- Each core issues one read or write at a time. The arbiter serialises the accesses, drives the memory port, and returns read data with a per-core valid pulse.
- Sits inside the processor top between the core instances and the data RAM. It is the only master of the RAM port.

Parameters:
- NUM_CORES, 3, number of requesting cores (2..8)
- ADDR_W, 16, memory address width
- DATA_W, 16, memory data width
- MEM_LAT, 1, RAM read latency in cycles (1..4), from address cycle to mem_rdata valid

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_CORES  per-core access request; level, held until grant
- we  in  NUM_CORES  per-core write enable (1=write, 0=read); qualified by req
- addr  in  NUM_CORES*ADDR_W  packed per-core addresses; core i at [i*ADDR_W +: ADDR_W]
- wdata  in  NUM_CORES*DATA_W  packed per-core write data
- grant  out  NUM_CORES  one-hot, one-cycle pulse: the request of core i is issued this cycle
- rvalid  out  NUM_CORES  one-hot, one-cycle pulse: rdata is valid for core i
- rdata  out  DATA_W  read data, broadcast to all cores, qualified by rvalid
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_we  out  1  RAM write strobe
- mem_rdata  in  DATA_W  RAM read data
- busy  out  1  high whenever the arbiter is not in IDLE

Behaviour:
- Reset (synchronous, active-high): state=IDLE, grant=0, rvalid=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, busy=0, rr_ptr=NUM_CORES-1 (so core 0 wins first).
- States: IDLE, ISSUE, WAIT_RD.
- IDLE: if req!=0, choose the winner w as the first requesting core after rr_ptr (modulo NUM_CORES). Latch w, we[w], addr[w] and wdata[w]. Go to ISSUE. Otherwise stay in IDLE.
- ISSUE (exactly one cycle):
  - grant[w]=1.
  - mem_addr/mem_wdata driven from the latched values; mem_we=latched we.
  - rr_ptr<=w.
  - For a write, go to IDLE. For a read, load lat_cnt=MEM_LAT-1 and go to WAIT_RD.
- WAIT_RD:
  - mem_addr is held; mem_we=0.
  - While lat_cnt!=0, decrement it.
  - When lat_cnt==0: rdata<=mem_rdata, and rvalid[w]=1 in the following cycle. That cycle is also the return to IDLE.
- Latency:
  - From req rising (arbiter in IDLE) to grant: 1 cycle.
  - Write throughput: one access per 2 cycles.
  - Read: rvalid arrives MEM_LAT+1 cycles after grant.
- Requester protocol: req/we/addr/wdata must be held stable until grant. A core may deassert req in the grant cycle. A core must not re-request before its rvalid for a read.
- A req that drops before grant is not an error: it is simply not sampled. Only the sampling cycle in IDLE matters.
- Simultaneous requests: exactly one grant; the others wait. With all cores requesting continuously, each core is served once per NUM_CORES accesses (no starvation).
- Only one access is outstanding at a time. No new arbitration takes place in ISSUE or WAIT_RD.
- Reset mid-operation: an in-flight read is abandoned with no rvalid, and arbitration restarts at core 0.
- Bits of we/addr/wdata for cores with req=0 are ignored.

Optional Feature:
- Macro: ARB_STATS_EN
- Defined:
  - Adds output conflict_cnt [15:0], which increments once per IDLE arbitration where two or more req bits are set. It saturates at 16'hFFFF and resets to 0.
  - Adds output access_cnt [15:0], which counts grants. It saturates and resets to 0.
- Undefined: neither port exists and there is no counter logic. Behaviour is otherwise identical.

Decomposition:
- Shared package: state encodings (ST_IDLE, ST_ISSUE, ST_WAIT_RD) and the default widths ADDR_W/DATA_W used by the processor top.
- One sub-module: rr_pick. It is a combinational round-robin picker with inputs req and rr_ptr, and outputs the winner index and a valid flag. It is reusable for the instruction-memory port.

Test Plan (all cases use NUM_CORES=3, MEM_LAT=1):
- Reset: hold rst for 3 cycles with all req=1 -> grant=0, rvalid=0, mem_we=0, busy=0 throughout. After release, the first grant is to core 0.
- Single write: core 1 writes addr 0x0010, data 0xABCD -> grant[1] 1 cycle later, with mem_we=1, mem_addr=0x0010, mem_wdata=0xABCD in that same cycle. Arbiter is back in IDLE the next cycle.
- Single read: core 2 reads addr 0x0004, RAM model holds 0x1234 -> grant[2] at T, rvalid[2] at T+2 with rdata=0x1234.
- Contention: all 3 cores hold read requests -> grant order 0,1,2,0,1,2 over 6 accesses, with no core granted twice before the others.
- Fairness after idle: only core 2 is served, then cores 0 and 2 request together -> core 0 is granted first.
- Reset mid-read: assert rst in WAIT_RD -> no rvalid pulse, busy=0 next cycle, and the next grant goes to core 0. With ARB_STATS_EN defined, the counters also read 0.
